// File: rtl/key_debounce_sched_pkg.sv
// rtl/key_debounce_sched_pkg.sv - shared FSM encoding and timing constants for the key debouncer
package key_debounce_sched_pkg;

    // Scheduler phases: scanning for a changed key, qualifying its new level, committing it
    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // 20 ms qualification window at 50 MHz
    localparam int unsigned CNT_MAX_DEFAULT  = 999_999;
    // Short window used in simulation
    localparam int unsigned CNT_MAX_SIM      = 24;
    localparam int unsigned CNT_W_DEFAULT    = 20;
    localparam int unsigned NUM_KEYS_DEFAULT = 4;

endpackage

// File: rtl/key_sync2.sv
// rtl/key_sync2.sv - parameterized-width two-flop synchronizer, resets to all ones
module key_sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the raw pins; reset value is "released" for active-low keys
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce_sched.sv
// rtl/key_debounce_sched.sv - round-robin debouncer sharing one stability counter across keys
module key_debounce_sched
    import key_debounce_sched_pkg::*;
#(
    parameter int unsigned NUM_KEYS = NUM_KEYS_DEFAULT,
    parameter int unsigned CNT_MAX  = CNT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [NUM_KEYS-1:0]         key_in,
    output logic [NUM_KEYS-1:0]         key_level,
    output logic [NUM_KEYS-1:0]         key_press,
    output logic [NUM_KEYS-1:0]         key_release,
    output logic                        busy,
    output logic [$clog2(NUM_KEYS)-1:0] cur_key
);

    localparam int unsigned PTR_W = $clog2(NUM_KEYS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [NUM_KEYS-1:0] ks;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    ptr_inc;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                ks_cur;
    logic                level_cur;

    key_sync2 #(
        .WIDTH (NUM_KEYS)
    ) u_sync (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (key_in),
        .q_o   (ks)
    );

    // Pointer advance with explicit wrap so non-power-of-two key counts stay in range
    always_comb begin
        ptr_inc   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        ks_cur    = ks[ptr_q];
        level_cur = level_q[ptr_q];
    end

    // Scheduler next-state: scan for a mismatch, qualify it, then commit the new level
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        case (state_q)
            ST_SCAN: begin
                if (ks_cur != level_cur) begin
                    state_d = ST_QUAL;
                    cnt_d   = '0;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            ST_QUAL: begin
                if (ks_cur == level_cur) begin
                    // Bounced back before the window closed: drop it and move on for fairness
                    state_d = ST_SCAN;
                    ptr_d   = ptr_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                level_d[ptr_q] = ~level_cur;
                if (level_cur) begin
                    press_d[ptr_q] = 1'b1;
                end else begin
                    release_d[ptr_q] = 1'b1;
                end
                ptr_d   = ptr_inc;
                state_d = ST_SCAN;
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Scheduler state, shared counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_SCAN;
            ptr_q     <= '0;
            cnt_q     <= '0;
            level_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign busy        = (state_q != ST_SCAN);
    assign cur_key     = ptr_q;

endmodule

// File: tb/tb_key_debounce_sched.sv
// tb/tb_key_debounce_sched.sv - scoreboard bench for the shared-counter key debouncer
module tb_key_debounce_sched;

    localparam int NK = 4;
    localparam int CM = 24;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [NK-1:0] key_in  = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          busy;
    logic [1:0]    cur_key;

    key_debounce_sched #(
        .NUM_KEYS (NK),
        .CNT_MAX  (CM),
        .CNT_W    (20)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .busy        (busy),
        .cur_key     (cur_key)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int press_cnt[NK];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: timestamps instead of a counter; a change qualifies once it has
    // been seen continuously for CM edges after detection, commit happens one edge later
    typedef struct {
        int key;
        bit press;
        int t;
    } ev_t;
    ev_t exp_q[$];

    logic [NK-1:0] m_s1  = '1;
    logic [NK-1:0] m_s2  = '1;
    logic [NK-1:0] m_lvl = '1;
    int            m_ptr = 0;
    int            q_start = -1;
    bit            committing = 1'b0;

    always @(posedge sys_clk) begin : model
        ev_t ev;
        cyc = cyc + 1;
        if (sys_rst) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '1;
            m_ptr = 0; q_start = -1; committing = 1'b0;
        end else begin
            if (committing) begin
                m_lvl[m_ptr] = ~m_lvl[m_ptr];
                ev.key = m_ptr; ev.press = (m_lvl[m_ptr] == 1'b0); ev.t = cyc;
                exp_q.push_back(ev);
                m_ptr = (m_ptr + 1) % NK;
                committing = 1'b0;
            end else if (q_start >= 0) begin
                if (m_s2[m_ptr] == m_lvl[m_ptr]) begin
                    q_start = -1;
                    m_ptr = (m_ptr + 1) % NK;
                end else if (cyc - q_start == CM) begin
                    q_start = -1;
                    committing = 1'b1;
                end
            end else if (m_s2[m_ptr] != m_lvl[m_ptr]) begin
                q_start = cyc;
            end else begin
                m_ptr = (m_ptr + 1) % NK;
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    end

    // Monitor: pops expected pulses due this cycle and compares against what the DUT shows
    always @(negedge sys_clk) begin : monitor
        logic [NK-1:0] ep;
        logic [NK-1:0] er;
        ev_t ev;
        ep = '0;
        er = '0;
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            ev = exp_q.pop_front();
            if (ev.t == cyc) begin
                if (ev.press) ep[ev.key] = 1'b1;
                else          er[ev.key] = 1'b1;
            end else begin
                chk("stale_expected_pulse", ev.t, cyc);
            end
        end
        if (cyc > 0) begin
            if ((ep | er | key_press | key_release) != '0) begin
                chk("key_press", int'(key_press), int'(ep));
                chk("key_release", int'(key_release), int'(er));
            end
            chk("key_level", int'(key_level), int'(m_lvl));
            chk("busy", int'(busy), int'((q_start >= 0) || committing));
            chk("cur_key", int'(cur_key), m_ptr);
            for (int k = 0; k < NK; k++) press_cnt[k] += int'(key_press[k]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_pulse(input int k, input bit press, output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (press ? key_press[k] : key_release[k]) begin
                t = cyc;
                return;
            end
        end
        chk("pulse_timeout", 0, 1);
    endtask

    // Wait until the scheduler is idle and a change driven now is detected with ptr==target
    task automatic align(input int target);
        for (int i = 0; i < 400; i++) begin
            if (q_start < 0 && !committing && ((m_ptr + 2) % NK) == target) return;
            tick(1);
        end
        chk("align_timeout", 0, 1);
    endtask

    initial begin : stim
        int d0, t0, t2, t3, pc, lvl_seen, busy_seen, ck;
        for (int k = 0; k < NK; k++) press_cnt[k] = 0;

        // Reset state
        sys_rst = 1'b1;
        tick(3);
        chk("reset_level", int'(key_level), 15);
        chk("reset_pulses", int'(key_press | key_release), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cur_key", int'(cur_key), 0);
        sys_rst = 1'b0;

        // Clean press with ptr==0 on detection: pulse CNT_MAX+4 edges after the drive
        align(0);
        key_in[0] = 1'b0;
        d0 = cyc;
        wait_pulse(0, 1'b1, t0);
        chk("press_latency", t0 - d0, CM + 4);
        chk("press_level", int'(key_level), 14);
        tick(60 - (cyc - d0));
        key_in[0] = 1'b1;
        wait_pulse(0, 1'b0, t0);
        chk("release_level", int'(key_level), 15);

        // Bounce on key 1, then settle low
        pc = press_cnt[1];
        for (int i = 0; i < 12; i++) begin
            key_in[1] = ~key_in[1];
            tick(5);
        end
        key_in[1] = 1'b0;
        tick(150);
        chk("bounce_one_press", press_cnt[1] - pc, 1);
        chk("bounce_level1", int'(key_level[1]), 0);
        key_in[1] = 1'b1;
        tick(150);

        // Simultaneous fall on keys 2 and 3
        align(0);
        key_in[3:2] = 2'b00;
        wait_pulse(2, 1'b1, t2);
        wait_pulse(3, 1'b1, t3);
        chk("simul_spacing_ok", int'(t3 - t2 >= CM + 2), 1);
        chk("simul_levels", int'(key_level[3:2]), 0);
        key_in[3:2] = 2'b11;
        tick(200);

        // Reset while the counter sits at 10
        align(0);
        pc = press_cnt[0];
        key_in[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q_start >= 0 && cyc - q_start == 10) break;
            tick(1);
        end
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        chk("midqual_reset_level", int'(key_level), 15);
        chk("midqual_no_pulse", press_cnt[0] - pc, 0);
        wait_pulse(0, 1'b1, t0);
        tick(2);
        chk("midqual_requalified", press_cnt[0] - pc, 1);
        key_in[0] = 1'b1;
        tick(150);

        // Short glitch: busy rises, aborts, pointer moves on to key 1
        align(0);
        pc = press_cnt[0];
        busy_seen = 0;
        key_in[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (busy) busy_seen = 1;
        end
        key_in[0] = 1'b1;
        ck = -1;
        for (int i = 0; i < 40; i++) begin
            lvl_seen = int'(busy);
            tick(1);
            if (busy) busy_seen = 1;
            if (lvl_seen == 1 && !busy && ck < 0) ck = int'(cur_key);
        end
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_cur_key", ck, 1);
        chk("glitch_no_pulse", press_cnt[0] - pc, 0);

        // Randomized traffic: holds, glitches and occasional resets
        for (int i = 0; i < 150; i++) begin
            int k;
            k = int'($urandom_range(0, NK - 1));
            key_in[k] = ~key_in[k];
            if ($urandom_range(0, 2) == 0) begin
                tick(int'($urandom_range(1, 30)));
                key_in[k] = ~key_in[k];
            end
            if ($urandom_range(0, 39) == 0) begin
                sys_rst = 1'b1;
                tick(int'($urandom_range(1, 2)));
                sys_rst = 1'b0;
            end
            tick(int'($urandom_range(1, 40)));
        end
        key_in = '1;
        tick(NK * (CM + 4) * 2 + 20);
        chk("final_level", int'(key_level), 15);
        chk("final_busy", int'(busy), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
